// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and helpers for the LFSR generator
// and its bounded-draw port.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        RESP = 2'd2
    } draw_state_e;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    // Smallest all-ones mask covering bound-1; zero for bound <= 1.
    function automatic logic [31:0] bound_mask(input logic [31:0] bound);
        logic [31:0] m;
        m = (bound == 32'd0) ? 32'd0 : (bound - 32'd1);
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_gen_step.sv
// Combinational STEP-shift Fibonacci engine: feedback is the XOR of the
// tapped state bits, shifted in at bit 0.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
    parameter int               STEP  = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] chain_s [0:STEP];

    assign chain_s[0] = state_i;

    for (genvar i = 0; i < STEP; i++) begin : g_shift
        assign chain_s[i+1] = {chain_s[i][WIDTH-2:0], ^(chain_s[i] & TAPS)};
    end

    assign state_o = chain_s[STEP];

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with runtime seed load, zero-lockup protection and a
// ready/valid bounded-draw port using rejection sampling.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
    parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               STEP      = 1,
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             next_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] rand_o,
    output logic             lockup_o,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OUT_W-1:0] bound_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [OUT_W-1:0] rsp_data_o
);

    localparam logic [WIDTH-1:0] ONE_C       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RESET_STATE = (SEED == '0) ? ONE_C : SEED;
    localparam int               TRY_W       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY    = TRY_W'(MAX_TRIES - 1);

    logic [WIDTH-1:0] state_q, state_d, stepped_s, pick_s;
    logic             lockup_q, lockup_d;
    logic             advance_s;
    draw_state_e      fsm_q, fsm_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0] bound_q, bound_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] mask_s, cand_s;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEP  (STEP)
    ) u_step (
        .state_i (state_q),
        .state_o (stepped_s)
    );

    // State update: load beats advance beats hold; a zero result becomes 1.
    always_comb begin
        advance_s = next_i | (fsm_q == DRAW);
        if (load_i) begin
            pick_s = seed_i;
        end else if (advance_s) begin
            pick_s = stepped_s;
        end else begin
            pick_s = state_q;
        end
        state_d  = (pick_s == '0) ? ONE_C : pick_s;
        lockup_d = load_i & (seed_i == '0);
    end

    assign mask_s = OUT_W'(bound_mask(32'(bound_q)));
    assign cand_s = state_q[OUT_W-1:0] & mask_s;

    // Draw FSM next-state and response data.
    always_comb begin
        fsm_d   = fsm_q;
        tries_d = tries_q;
        bound_d = bound_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (fsm_q)
            IDLE: begin
                if (req_valid_i) begin
                    bound_d = bound_i;
                    tries_d = '0;
                    if (bound_i <= OUT_W'(1)) begin
                        data_d  = '0;
                        valid_d = 1'b1;
                        fsm_d   = RESP;
                    end else begin
                        fsm_d = DRAW;
                    end
                end else begin
                    fsm_d = IDLE;
                end
            end
            DRAW: begin
                if (cand_s < bound_q) begin
                    data_d  = cand_s;
                    valid_d = 1'b1;
                    fsm_d   = RESP;
                end else if (tries_q == LAST_TRY) begin
                    // cand <= mask < 2*bound, so one subtraction lands in range
                    data_d  = cand_s - bound_q;
                    valid_d = 1'b1;
                    fsm_d   = RESP;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    valid_d = 1'b0;
                    fsm_d   = IDLE;
                end else begin
                    fsm_d = RESP;
                end
            end
            default: begin
                valid_d = 1'b0;
                fsm_d   = IDLE;
            end
        endcase
    end

    // State, FSM and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RESET_STATE;
            lockup_q <= 1'b0;
            fsm_q    <= IDLE;
            tries_q  <= '0;
            bound_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
            fsm_q    <= fsm_d;
            tries_q  <= tries_d;
            bound_q  <= bound_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign rand_o      = state_q;
    assign lockup_o    = lockup_q;
    assign req_ready_o = (fsm_q == IDLE);
    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a default instance and a STEP=4/MAX_TRIES=1 instance
// share stimulus; both are compared each cycle against a behavioural model.
module tb_lfsr_gen;

    logic        clk, rst_i, next_i, load_i, req_valid_i, rsp_ready_i;
    logic [15:0] seed_i;
    logic [7:0]  bound_i;
    logic [15:0] rand_a, rand_b;
    logic        lock_a, lock_b, rdy_a, rdy_b, val_a, val_b;
    logic [7:0]  dat_a, dat_b;

    int checks = 0;
    int failures = 0;

    lfsr_gen u_a (
        .clk_i(clk), .rst_i(rst_i), .next_i(next_i), .load_i(load_i),
        .seed_i(seed_i), .rand_o(rand_a), .lockup_o(lock_a),
        .req_valid_i(req_valid_i), .req_ready_o(rdy_a), .bound_i(bound_i),
        .rsp_valid_o(val_a), .rsp_ready_i(rsp_ready_i), .rsp_data_o(dat_a)
    );

    lfsr_gen #(.STEP(4), .MAX_TRIES(1)) u_b (
        .clk_i(clk), .rst_i(rst_i), .next_i(next_i), .load_i(load_i),
        .seed_i(seed_i), .rand_o(rand_b), .lockup_o(lock_b),
        .req_valid_i(req_valid_i), .req_ready_o(rdy_b), .bound_i(bound_i),
        .rsp_valid_o(val_b), .rsp_ready_i(rsp_ready_i), .rsp_data_o(dat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_step [2] = '{1, 4};
    int          m_max  [2] = '{4, 1};
    logic [15:0] m_st   [2];
    int          m_ph   [2];  // 0 idle, 1 draw, 2 resp
    int          m_tries[2];
    int          m_bnd  [2];
    logic [7:0]  m_dat  [2];
    bit          m_val  [2];
    bit          m_lock [2];

    function automatic logic [15:0] m_shift(logic [15:0] s, int n);
        for (int k = 0; k < n; k++) begin
            s = {s[14:0], ($countones(s & 16'hB400) % 2) == 1};
        end
        return s;
    endfunction

    function automatic int m_mask(int b);
        int k = 0;
        while (((1 << k) - 1) < (b - 1)) k++;
        return (1 << k) - 1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 16'h0001; m_ph[i] = 0; m_tries[i] = 0; m_bnd[i] = 0;
            m_dat[i] = 8'h00; m_val[i] = 1'b0; m_lock[i] = 1'b0;
        end
    endtask

    task automatic m_update(int i);
        logic [15:0] old, ns;
        int cand;
        old = m_st[i];
        if (load_i)
            ns = (seed_i == 16'h0) ? 16'h0001 : seed_i;
        else if (next_i || m_ph[i] == 1)
            ns = m_shift(old, m_step[i]);
        else
            ns = old;
        if (ns == 16'h0) ns = 16'h0001;
        m_lock[i] = load_i && (seed_i == 16'h0);
        case (m_ph[i])
            0: if (req_valid_i) begin
                m_bnd[i] = int'(bound_i);
                m_tries[i] = 0;
                if (bound_i <= 8'd1) begin
                    m_dat[i] = 8'h00; m_val[i] = 1'b1; m_ph[i] = 2;
                end else begin
                    m_ph[i] = 1;
                end
            end
            1: begin
                cand = int'(old[7:0]) & m_mask(m_bnd[i]);
                if (cand < m_bnd[i]) begin
                    m_dat[i] = 8'(cand); m_val[i] = 1'b1; m_ph[i] = 2;
                end else if (m_tries[i] == m_max[i] - 1) begin
                    m_dat[i] = 8'(cand - m_bnd[i]); m_val[i] = 1'b1; m_ph[i] = 2;
                end else begin
                    m_tries[i]++;
                end
            end
            default: if (rsp_ready_i) begin
                m_val[i] = 1'b0; m_ph[i] = 0;
            end
        endcase
        m_st[i] = ns;
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a.rand",  32'(rand_a), 32'(m_st[0]));
        check("a.lock",  32'(lock_a), 32'(m_lock[0]));
        check("a.ready", 32'(rdy_a),  32'(m_ph[0] == 0));
        check("a.valid", 32'(val_a),  32'(m_val[0]));
        check("a.data",  32'(dat_a),  32'(m_dat[0]));
        check("b.rand",  32'(rand_b), 32'(m_st[1]));
        check("b.lock",  32'(lock_b), 32'(m_lock[1]));
        check("b.ready", 32'(rdy_b),  32'(m_ph[1] == 0));
        check("b.valid", 32'(val_b),  32'(m_val[1]));
        check("b.data",  32'(dat_b),  32'(m_dat[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        m_update(0);
        m_update(1);
        #1;
        compare_all();
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        #1;
        m_reset();
        compare_all();
        #1;
        rst_i = 1'b0;
    endtask

    task automatic idle_inputs();
        next_i = 1'b0; load_i = 1'b0; seed_i = 16'h0;
        req_valid_i = 1'b0; bound_i = 8'h0;
    endtask

    task automatic accept(logic [7:0] b);
        req_valid_i = 1'b1; bound_i = b;
        tick();
        req_valid_i = 1'b0;
    endtask

    // Called right after the acceptance edge; latency counts that edge.
    task automatic wait_rsp_a(output int lat);
        lat = 1;
        while (!val_a && lat < 20) begin
            tick();
            lat++;
        end
        check("a.rsp_timeout", 32'(val_a), 32'd1);
    endtask

    typedef struct {
        bit          nxt;
        bit          ld;
        logic [15:0] seed;
        logic [15:0] exp_rand;
        bit          exp_lock;
    } vec_t;

    vec_t vecs[15];
    int   lat;
    logic [7:0] held;

    initial begin
        rst_i = 1'b0; rsp_ready_i = 1'b1;
        idle_inputs();

        for (int i = 0; i < 11; i++)
            vecs[i] = '{1'b1, 1'b0, 16'h0, (i < 10) ? (16'h0002 << i) : 16'h0801, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'hACE1, 16'hACE1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 16'hACE1, 1'b0};

        reset_dut();
        check("reset.rand", 32'(rand_a), 32'h0001);
        check("reset.ready", 32'(rdy_a), 32'd1);

        for (int i = 0; i < 15; i++) begin
            next_i = vecs[i].nxt; load_i = vecs[i].ld; seed_i = vecs[i].seed;
            tick();
            check($sformatf("vec%0d.rand", i), 32'(rand_a), 32'(vecs[i].exp_rand));
            check($sformatf("vec%0d.lock", i), 32'(lock_a), 32'(vecs[i].exp_lock));
            if (i == 0) check("step4.one", 32'(rand_b), 32'h0010);
            if (i == 1) check("step4.two", 32'(rand_b), 32'h0100);
        end
        idle_inputs();

        // Bound 5 from seed 1, then bound 0 without consuming the LFSR.
        reset_dut();
        accept(8'd5);
        wait_rsp_a(lat);
        check("b5.latency", 32'(lat), 32'd2);
        check("b5.data", 32'(dat_a), 32'd1);
        check("b5.rand", 32'(rand_a), 32'h0002);
        tick();
        accept(8'd0);
        check("b0.valid", 32'(val_a), 32'd1);
        check("b0.data", 32'(dat_a), 32'd0);
        check("b0.rand", 32'(rand_a), 32'h0002);
        tick();

        // Seed 7, bound 5: u_b rejects once and folds; next_i overlaps DRAW.
        load_i = 1'b1; seed_i = 16'h0007;
        tick();
        idle_inputs();
        accept(8'd5);
        next_i = 1'b1;
        tick();
        next_i = 1'b0;
        check("t1.valid", 32'(val_b), 32'd1);
        check("t1.data", 32'(dat_b), 32'd2);
        check("t1.rand_once", 32'(rand_b), 32'h0070);
        check("a.rand_once", 32'(rand_a), 32'h000E);
        wait_rsp_a(lat);
        check("a.seed7.data", 32'(dat_a), 32'd4);
        check("a.seed7.rand", 32'(rand_a), 32'h0038);
        tick();

        // Backpressure: response held stable, no new request accepted.
        rsp_ready_i = 1'b0;
        accept(8'd200);
        wait_rsp_a(lat);
        held = m_dat[0];
        req_valid_i = 1'b1; bound_i = 8'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp.data", 32'(dat_a), 32'(held));
            check("bp.ready", 32'(rdy_a), 32'd0);
            check("bp.valid", 32'(val_a), 32'd1);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        check("bp.release", 32'(rdy_a), 32'd1);

        // Asynchronous reset in the middle of a draw.
        accept(8'd250);
        #3;
        rst_i = 1'b1;
        #1;
        check("arst.rand_a", 32'(rand_a), 32'h0001);
        check("arst.rand_b", 32'(rand_b), 32'h0001);
        check("arst.valid", 32'(val_a), 32'd0);
        check("arst.ready", 32'(rdy_a), 32'd1);
        m_reset();
        compare_all();
        rst_i = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            next_i      = ($urandom % 4) == 0;
            load_i      = ($urandom % 16) == 0;
            seed_i      = (($urandom % 4) == 0) ? 16'h0 : 16'($urandom);
            req_valid_i = ($urandom % 3) == 0;
            bound_i     = (($urandom % 8) == 0) ? 8'($urandom % 3) : 8'($urandom);
            rsp_ready_i = ($urandom % 2) == 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the fixed 16-bit Fibonacci LFSR.
- Configurable width, tap mask, seed and shifts-per-advance.
- Adds runtime seed load with zero-lockup protection.
- Adds a ready/valid bounded-draw port that returns a value in [0, bound) using rejection sampling. Game logic uses it for obstacle spacing and type selection.

Parameters:
- WIDTH, 16: LFSR state width; legal range 4..32.
- TAPS, 16'hB400: feedback mask; bit i set means state[i] feeds the XOR.
- SEED, 1: reset state; a value of 0 is replaced by 1.
- STEP, 1: shifts applied per advance; legal range 1..WIDTH.
- OUT_W, 8: bounded-draw data width; must be ≤ WIDTH.
- MAX_TRIES, 4: maximum candidates examined per draw; must be ≥ 1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- next_i  input  1  advance the LFSR by STEP shifts.
- load_i  input  1  load seed_i into state.
- seed_i  input  WIDTH  runtime seed.
- rand_o  output  WIDTH  current state.
- lockup_o  output  1  one-cycle pulse: a zero seed was loaded and substituted.
- req_valid_i  input  1  bounded-draw request valid.
- req_ready_o  output  1  request accepted when high together with req_valid_i.
- bound_i  input  OUT_W  exclusive upper bound of the draw.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed.
- rsp_data_o  output  OUT_W  drawn value.

Behaviour:
- Single shift: fb = XOR-reduce(state & TAPS); state <= {state[WIDTH-2:0], fb}.
- One advance = STEP chained shifts, computed combinationally, taking effect in one cycle.
- Reset (async, rst_i high):
  - state = SEED, or 1 if SEED == 0.
  - FSM in IDLE; tries = 0.
  - Outputs: lockup_o = 0, rsp_valid_o = 0, rsp_data_o = 0, req_ready_o = 1 once reset deasserts.
- State update priority: load_i > advance > hold.
- Advance request = next_i OR (FSM in DRAW). If both occur in the same cycle, the LFSR advances once only.
- Load:
  - seed_i != 0: state <= seed_i; lockup_o = 0.
  - seed_i == 0: state <= 1; lockup_o = 1 in the following cycle.
  - A load during DRAW overrides the advance. The candidate for that cycle is still taken from the pre-load rand_o.
- State is never 0. Any illegal all-zero state is forced to 1 on the next clock; no lockup pulse is raised for this case.
- FSM states:
  - IDLE: req_ready_o = 1. On req_valid_i, latch bound_i and clear tries.
    - bound == 0 or bound == 1 → RESP with data 0; no LFSR consumption.
    - Otherwise → DRAW.
  - DRAW:
    - mask = 2^k − 1, with k the smallest value such that 2^k − 1 ≥ bound − 1.
    - cand = rand_o[OUT_W-1:0] & mask. The LFSR advances every DRAW cycle.
    - cand < bound → data = cand, go to RESP.
    - Else if tries == MAX_TRIES − 1 → data = cand − bound (always < bound because cand ≤ mask < 2·bound), go to RESP.
    - Else tries++ and stay in DRAW.
  - RESP: rsp_valid_o = 1 and rsp_data_o held stable. On rsp_ready_i → IDLE.
    - req_ready_o = 0 in DRAW and RESP.
- Latency, from the acceptance edge to rsp_valid_o:
  - Bound ≤ 1: 1 cycle.
  - Bound ≥ 2: 1 + number of DRAW cycles, between 1 and MAX_TRIES.
- rsp_valid_o is registered; there is no combinational path from any input to any output.

Decomposition:
- lfsr_pkg holds:
  - draw_state_e enum (IDLE, DRAW, RESP).
  - Default TAPS constant for widths 8, 16 and 32.
  - Function bound_mask(bound) returning the power-of-two mask.
- Sub-module lfsr_step: purely combinational STEP-shift engine, parametrised by WIDTH/TAPS/STEP, taking state in and returning next state out.
- lfsr_gen holds the state register, load logic and draw FSM.

Test Plan:
- Default params, reset, then 11 next_i pulses → rand_o = 0x0002, 0x0004 … 0x0400, then 0x0801 on the 11th.
- load_i with seed_i = 0 → rand_o = 0x0001 next cycle, lockup_o high for exactly one cycle; load 0xACE1 → rand_o = 0xACE1, no pulse.
- STEP = 4, after reset → one next_i gives rand_o = 0x0010; two give 0x0100.
- After reset, request bound = 5 with rsp_ready_i = 1 → rsp_valid_o 2 cycles after acceptance, rsp_data_o = 1, rand_o = 0x0002. Request bound = 0 → data 0 after 1 cycle, rand_o unchanged.
- MAX_TRIES = 1, load 0x0007, bound = 5 → candidate 7 rejected, rsp_data_o = 2. next_i asserted during DRAW → rand_o advances once, not twice.
- Backpressure: hold rsp_ready_i low for 3 cycles → rsp_data_o stable and req_ready_o low throughout. Assert rst_i mid-DRAW → rsp_valid_o = 0 and rand_o = SEED immediately (async).
